rd_ptr_ctrl: RTL

Read-side pointer and status controller for the asynchronous FIFO, in the read clock domain. It keeps a binary read address and a registered Gray-coded read pointer. From the synchronised Gray write pointer it derives registered empty, almost-empty and occupancy-level outputs. It generalises the basic read-pointer block with a programmable almost-empty threshold, an occupancy count and an optional sticky underflow detector.

---
 rtl/rd_ptr_if.sv | 45 ++++
 rtl/rd_ptr_ctrl.sv | 73 +++++++
 2 files changed

// File: rtl/rd_ptr_if.sv
// Read-side FIFO pointer/status bundle between the read logic (slave) and its user (master).
// runderflow and rclr_err take part only when RD_UNDERFLOW_EN is defined.
interface rd_ptr_if #(
    parameter int ADDRSIZE = 9
);
    logic                rinc;
    logic [ADDRSIZE:0]   rwptr_sync;
    logic                rclr_err;
    logic [ADDRSIZE-1:0] raddr;
    logic [ADDRSIZE:0]   rptr;
    logic                rempty;
    logic                raempty;
    logic [ADDRSIZE:0]   rlevel;
`ifdef RD_UNDERFLOW_EN
    logic                runderflow;
`endif

    modport master (
        output rinc,
        output rwptr_sync,
        output rclr_err,
`ifdef RD_UNDERFLOW_EN
        input  runderflow,
`endif
        input  raddr,
        input  rptr,
        input  rempty,
        input  raempty,
        input  rlevel
    );

    modport slave (
        input  rinc,
        input  rwptr_sync,
`ifdef RD_UNDERFLOW_EN
        input  rclr_err,
        output runderflow,
`endif
        output raddr,
        output rptr,
        output rempty,
        output raempty,
        output rlevel
    );
endinterface

// File: rtl/rd_ptr_ctrl.sv
// Async-FIFO read pointer/status: a read moves raddr/rptr on the same edge, flags follow 1 rclk after rwptr_sync.
// Reads while empty are dropped; RD_UNDERFLOW_EN adds a sticky runderflow flag cleared by rclr_err.
module rd_ptr_ctrl #(
    parameter int ADDRSIZE  = 9,
    parameter int AE_THRESH = 4
) (
    input  logic     rclk,
    input  logic     r_rst,
    rd_ptr_if.slave  bus
);
    localparam int PW = ADDRSIZE + 1;
    localparam logic [ADDRSIZE:0] AE_LVL = PW'(AE_THRESH);

    logic [ADDRSIZE:0] rbin_q, rbin_d;
    logic [ADDRSIZE:0] rptr_q, rgray_d;
    logic [ADDRSIZE:0] rlevel_q, level_d;
    logic [ADDRSIZE:0] wbin;
    logic              rempty_q, raempty_q;
    logic              rd_en;

    always_comb begin
        rd_en   = bus.rinc & ~rempty_q;
        rbin_d  = rbin_q + {{ADDRSIZE{1'b0}}, rd_en};
        rgray_d = (rbin_d >> 1) ^ rbin_d;
        // Each binary bit is the XOR of all Gray bits at and above it.
        wbin = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            wbin[i] = ^(bus.rwptr_sync >> i);
        end
        level_d = wbin - rbin_d;
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            rbin_q    <= '0;
            rptr_q    <= '0;
            rempty_q  <= 1'b1;
            raempty_q <= 1'b1;
            rlevel_q  <= '0;
        end else begin
            rbin_q    <= rbin_d;
            rptr_q    <= rgray_d;
            rempty_q  <= (rgray_d == bus.rwptr_sync);
            raempty_q <= (level_d <= AE_LVL);
            rlevel_q  <= level_d;
        end
    end

    assign bus.raddr   = rbin_q[ADDRSIZE-1:0];
    assign bus.rptr    = rptr_q;
    assign bus.rempty  = rempty_q;
    assign bus.raempty = raempty_q;
    assign bus.rlevel  = rlevel_q;

`ifdef RD_UNDERFLOW_EN
    logic runderflow_q, runderflow_d;

    // A new underflow outranks a clear arriving in the same cycle.
    always_comb begin
        runderflow_d = (bus.rinc & rempty_q) | (runderflow_q & ~bus.rclr_err);
    end

    always_ff @(posedge rclk or posedge r_rst) begin
        if (r_rst) begin
            runderflow_q <= 1'b0;
        end else begin
            runderflow_q <= runderflow_d;
        end
    end

    assign bus.runderflow = runderflow_q;
`endif
endmodule
